// File: rtl/mc_main_controller.sv
// Multi-cycle MIPS-subset main controller: Moore FSM driving datapath enables and
// mux selects, with alu_op looked ahead from next_state for the registered ALU control.
module mc_main_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_load,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       done;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   op_legal;

  // Moore output set for each state; registered one state ahead alongside state_q.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.done = 1'b1; end
      S_R_EXEC:    c.alu_src_a = 1'b1;
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1; end
      S_BRANCH:    begin c.alu_src_a = 1'b1; c.pc_write_cond = 1'b1; c.pc_src = 2'b01; c.done = 1'b1; end
      S_JUMP:      begin c.pc_write = 1'b1; c.pc_src = 2'b10; c.done = 1'b1; end
      S_I_EXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_I_WB:      begin c.reg_write = 1'b1; c.done = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI) ||
               (opcode == OP_SLTI);
  end

  // Reset folds into next_state so the alu_op look-ahead holds add while rst is high.
  always_comb begin
    next_state = S_FETCH;
    if (!rst) begin
      case (state_q)
        S_FETCH: next_state = S_DECODE;
        S_DECODE: begin
          if (opcode == OP_R)                            next_state = S_R_EXEC;
          else if (opcode == OP_LW || opcode == OP_SW)   next_state = S_MEM_ADDR;
          else if (opcode == OP_BEQ)                     next_state = S_BRANCH;
          else if (opcode == OP_J)                       next_state = S_JUMP;
          else if (opcode == OP_ADDI || opcode == OP_SLTI) next_state = S_I_EXEC;
          else                                           next_state = S_FETCH;
        end
        S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ: next_state = S_MEM_WB;
        S_R_EXEC:   next_state = S_R_WB;
        S_I_EXEC:   next_state = S_I_WB;
        default:    next_state = S_FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op = 2'b01;
    case (next_state)
      S_R_EXEC: alu_op = 2'b00;
      S_BRANCH: alu_op = 2'b10;
      S_I_EXEC: alu_op = (opcode == OP_SLTI) ? 2'b11 : 2'b01;
      default:  alu_op = 2'b01;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= next_state;
      ctrl_q  <= decode_ctrl(next_state);
    end
  end

  // Write strobes are masked while rst is high so an abandoned instruction writes nothing.
  assign pc_write      = ctrl_q.pc_write & ~rst;
  assign pc_write_cond = ctrl_q.pc_write_cond & ~rst;
  assign pc_load       = pc_write | (pc_write_cond & zero);
  assign pc_src        = ctrl_q.pc_src;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read & ~rst;
  assign mem_write     = ctrl_q.mem_write & ~rst;
  assign ir_write      = ctrl_q.ir_write & ~rst;
  assign reg_write     = ctrl_q.reg_write & ~rst;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign state         = state_q;
  assign instr_done    = ~rst & (ctrl_q.done | ((state_q == S_DECODE) & ~op_legal));

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: per-cycle vector table plus
// cycles-per-instruction sequences bounded by a cycle budget.
module tb_mc_main_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_load, pc_write, pc_write_cond;
  logic [1:0] pc_src;
  logic       i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic       instr_done;

  mc_main_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_load(pc_load), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_load, pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
  //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done}
  logic [17:0] act;
  assign act = {pc_load, pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                instr_done};

  localparam logic [17:0] O_FETCH = 18'b1_1_0_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [17:0] O_DEC   = 18'b0_0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [17:0] O_MADDR = 18'b0_0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [17:0] O_MRD   = 18'b0_0_0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [17:0] O_MWB   = 18'b0_0_0_00_0_0_0_0_1_0_1_0_00_00_1;
  localparam logic [17:0] O_MWR   = 18'b0_0_0_00_1_0_1_0_0_0_0_0_00_00_1;
  localparam logic [17:0] O_REX   = 18'b0_0_0_00_0_0_0_0_0_0_0_1_00_00_0;
  localparam logic [17:0] O_RWB   = 18'b0_0_0_00_0_0_0_0_1_1_0_0_00_00_1;
  localparam logic [17:0] O_BRN   = 18'b0_0_1_01_0_0_0_0_0_0_0_1_00_00_1;
  localparam logic [17:0] O_BRT   = 18'b1_0_1_01_0_0_0_0_0_0_0_1_00_00_1;
  localparam logic [17:0] O_JMP   = 18'b1_1_0_10_0_0_0_0_0_0_0_0_00_00_1;
  localparam logic [17:0] O_IEX   = 18'b0_0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [17:0] O_IWB   = 18'b0_0_0_00_0_0_0_0_1_0_0_0_00_00_1;
  localparam logic [17:0] O_RST   = 18'b0_0_0_00_0_0_0_0_0_0_0_0_01_01_0;
  localparam logic [17:0] O_RSTRD = 18'b0_0_0_00_1_0_0_0_0_0_0_0_00_01_0;
  localparam logic [17:0] A_R   = 18'd0;
  localparam logic [17:0] A_ADD = 18'd2;
  localparam logic [17:0] A_SUB = 18'd4;
  localparam logic [17:0] A_SLT = 18'd6;
  localparam logic [17:0] DONE  = 18'd1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic [3:0] st, input logic [17:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check_cycle(input int idx, input logic [3:0] st, input logic [17:0] exp);
    checks++;
    if (state === st && act === exp) passed++;
    else $display("FAIL vec%0d: state=%0d outs=%b, required state=%0d outs=%b",
                  idx, state, act, st, exp);
  endtask

  // Runs one instruction from FETCH and counts cycles up to the instr_done pulse.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input int exp_cyc);
    int cyc;
    bit seen;
    cyc = 0; seen = 0;
    opcode = op; zero = z;
    for (int k = 0; k < 8 && !seen; k++) begin
      #1;
      cyc++;
      if (instr_done === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen && cyc == exp_cyc) passed++;
    else $display("FAIL cpi_%s: cycles=%0d done_seen=%0d, required cycles=%0d",
                  name, cyc, seen, exp_cyc);
    #1;
    checks++;
    if (state === 4'd0) passed++;
    else $display("FAIL back_to_fetch_%s: state=%0d, required 0", name, state);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; zero = 1'b0;

    // Reset, then R-type
    add(1, 6'b000000, 0, 4'd0, O_RST);
    add(1, 6'b000000, 0, 4'd0, O_RST);
    add(0, 6'b000000, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b000000, 0, 4'd1, O_DEC   | A_R);
    add(0, 6'b000000, 0, 4'd6, O_REX   | A_ADD);
    add(0, 6'b000000, 0, 4'd7, O_RWB   | A_ADD);
    // lw
    add(0, 6'b100011, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b100011, 0, 4'd1, O_DEC   | A_ADD);
    add(0, 6'b100011, 0, 4'd2, O_MADDR | A_ADD);
    add(0, 6'b100011, 0, 4'd3, O_MRD   | A_ADD);
    add(0, 6'b100011, 0, 4'd4, O_MWB   | A_ADD);
    // sw
    add(0, 6'b101011, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b101011, 0, 4'd1, O_DEC   | A_ADD);
    add(0, 6'b101011, 0, 4'd2, O_MADDR | A_ADD);
    add(0, 6'b101011, 0, 4'd5, O_MWR   | A_ADD);
    // beq taken; zero held high to show it only matters in BRANCH
    add(0, 6'b000100, 1, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b000100, 1, 4'd1, O_DEC   | A_SUB);
    add(0, 6'b000100, 1, 4'd8, O_BRT   | A_ADD);
    // beq not taken
    add(0, 6'b000100, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b000100, 0, 4'd1, O_DEC   | A_SUB);
    add(0, 6'b000100, 0, 4'd8, O_BRN   | A_ADD);
    // j
    add(0, 6'b000010, 1, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b000010, 1, 4'd1, O_DEC   | A_ADD);
    add(0, 6'b000010, 1, 4'd9, O_JMP   | A_ADD);
    // slti
    add(0, 6'b001010, 0, 4'd0,  O_FETCH | A_ADD);
    add(0, 6'b001010, 0, 4'd1,  O_DEC   | A_SLT);
    add(0, 6'b001010, 0, 4'd10, O_IEX   | A_ADD);
    add(0, 6'b001010, 0, 4'd11, O_IWB   | A_ADD);
    // addi
    add(0, 6'b001000, 0, 4'd0,  O_FETCH | A_ADD);
    add(0, 6'b001000, 0, 4'd1,  O_DEC   | A_ADD);
    add(0, 6'b001000, 0, 4'd10, O_IEX   | A_ADD);
    add(0, 6'b001000, 0, 4'd11, O_IWB   | A_ADD);
    // lw abandoned by reset in MEM_READ
    add(0, 6'b100011, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b100011, 0, 4'd1, O_DEC   | A_ADD);
    add(0, 6'b100011, 0, 4'd2, O_MADDR | A_ADD);
    add(1, 6'b100011, 0, 4'd3, O_RSTRD);
    add(1, 6'b100011, 0, 4'd0, O_RST);
    add(0, 6'b100011, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b100011, 0, 4'd1, O_DEC   | A_ADD);
    add(0, 6'b100011, 0, 4'd2, O_MADDR | A_ADD);
    add(0, 6'b100011, 0, 4'd3, O_MRD   | A_ADD);
    add(0, 6'b100011, 0, 4'd4, O_MWB   | A_ADD);
    // illegal opcode
    add(0, 6'b111111, 0, 4'd0, O_FETCH | A_ADD);
    add(0, 6'b111111, 0, 4'd1, O_DEC   | A_ADD | DONE);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z;
      #1;
      check_cycle(i, vecs[i].st, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Cycles per instruction, FETCH to final state inclusive
    rst = 1'b0;
    run_instr("lw",      6'b100011, 0, 5);
    run_instr("sw",      6'b101011, 0, 4);
    run_instr("rtype",   6'b000000, 0, 4);
    run_instr("beq_t",   6'b000100, 1, 3);
    run_instr("beq_n",   6'b000100, 0, 3);
    run_instr("j",       6'b000010, 0, 3);
    run_instr("slti",    6'b001010, 0, 4);
    run_instr("illegal", 6'b110011, 0, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
